// File: rtl/blk_deframer_if.sv
// Handshake bundle for the block deframer: compressed beat stream in,
// assembled block stream out, plus the framing-error pulse.
interface blk_deframer_if #(
   parameter int D_BITWIDTH = 64,
   parameter int BEATS      = 8
);
   logic [D_BITWIDTH-1:0]       data_i;
   logic                        valid_i;
   logic                        ready_o;
   logic                        sop_i;
   logic                        eop_i;
   logic [1:0]                  mode_i;
   logic [D_BITWIDTH*BEATS-1:0] blk_data_o;
   logic [1:0]                  blk_mode_o;
   logic                        blk_valid_o;
   logic                        blk_ready_i;
   logic                        err_o;
   logic [1:0]                  err_code_o;

   modport master (
      output data_i, valid_i, sop_i, eop_i, mode_i, blk_ready_i,
      input  ready_o, blk_data_o, blk_mode_o, blk_valid_o, err_o, err_code_o
   );

   modport slave (
      input  data_i, valid_i, sop_i, eop_i, mode_i, blk_ready_i,
      output ready_o, blk_data_o, blk_mode_o, blk_valid_o, err_o, err_code_o
   );
endinterface

// File: rtl/blk_deframer.sv
// Block deframer: collects BEATS-beat bursts into a block, checks sop/eop
// framing, and queues complete blocks in a SLOTS-deep FIFO for the decoder.
module blk_deframer #(
   parameter int D_BITWIDTH = 64,
   parameter int BEATS      = 8,
   parameter int SLOTS      = 2
) (
   input logic           clk,
   input logic           rst_n,
   blk_deframer_if.slave bus
);
   localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int CTW = $clog2(SLOTS + 1);
   localparam int BW  = D_BITWIDTH * BEATS;

   localparam logic [1:0] ERR_SOP    = 2'b01;
   localparam logic [1:0] ERR_ORPHAN = 2'b10;
   localparam logic [1:0] ERR_LEN    = 2'b11;

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t                              state_q, state_d;
   logic [CW-1:0]                       cnt_q, cnt_d;
   logic [1:0]                          mode_q;
   logic [BEATS-2:0][D_BITWIDTH-1:0]    asm_q;
   logic [BW-1:0]                       buf_data [SLOTS];
   logic [1:0]                          buf_mode [SLOTS];
   logic [PW-1:0]                       wr_ptr_q, rd_ptr_q;
   logic [CTW-1:0]                      count_q;
   logic                                err_q, err_d;
   logic [1:0]                          code_q, code_d;

   logic                                ready, beat_acc, pop, commit;
   logic                                store, cap_mode;
   logic [CW-1:0]                       store_idx;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(SLOTS - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake and head-of-FIFO outputs; ready depends on occupancy only.
   always_comb begin
      ready           = (count_q < CTW'(SLOTS));
      beat_acc        = bus.valid_i & ready;
      pop             = (count_q != '0) & bus.blk_ready_i;
      bus.ready_o     = ready;
      bus.blk_valid_o = (count_q != '0);
      bus.blk_data_o  = (count_q != '0) ? buf_data[rd_ptr_q] : '0;
      bus.blk_mode_o  = (count_q != '0) ? buf_mode[rd_ptr_q] : '0;
      bus.err_o       = err_q;
      bus.err_code_o  = code_q;
   end

   // Framing FSM: next state, beat placement, commit and error decisions.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      store     = 1'b0;
      store_idx = cnt_q;
      cap_mode  = 1'b0;
      commit    = 1'b0;
      err_d     = 1'b0;
      code_d    = '0;
      if (beat_acc) begin
         unique case (state_q)
            IDLE: begin
               if (!bus.sop_i) begin
                  err_d  = 1'b1;
                  code_d = ERR_ORPHAN;
               end else if (bus.eop_i) begin
                  err_d  = 1'b1;
                  code_d = ERR_LEN;
               end else begin
                  store     = 1'b1;
                  store_idx = '0;
                  cap_mode  = 1'b1;
                  cnt_d     = CW'(1);
                  state_d   = COLLECT;
               end
            end
            COLLECT: begin
               if (bus.sop_i) begin
                  // Restart on the new sop; a restart that also carries eop
                  // is a one-beat block and is dropped under the same pulse.
                  err_d  = 1'b1;
                  code_d = ERR_SOP;
                  if (bus.eop_i) begin
                     cnt_d   = '0;
                     state_d = IDLE;
                  end else begin
                     store     = 1'b1;
                     store_idx = '0;
                     cap_mode  = 1'b1;
                     cnt_d     = CW'(1);
                  end
               end else if (cnt_q == CW'(BEATS - 1)) begin
                  cnt_d   = '0;
                  state_d = IDLE;
                  if (bus.eop_i) begin
                     commit = 1'b1;
                  end else begin
                     err_d  = 1'b1;
                     code_d = ERR_LEN;
                  end
               end else if (bus.eop_i) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  store = 1'b1;
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Control state, FIFO pointers/occupancy and the registered error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
         code_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         code_q  <= code_d;
         if (commit) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (commit && !pop)      count_q <= count_q + CTW'(1);
         else if (!commit && pop) count_q <= count_q - CTW'(1);
      end
   end

   // Datapath storage; contents are only observed when occupancy says so.
   always_ff @(posedge clk) begin
      if (store)    asm_q[store_idx] <= bus.data_i;
      if (cap_mode) mode_q <= bus.mode_i;
      if (commit) begin
         buf_data[wr_ptr_q] <= {bus.data_i, asm_q};
         buf_mode[wr_ptr_q] <= mode_q;
      end
   end
endmodule

// File: doc/blk_deframer.md
BLK_DEFRAMER -- requirements
Module: blk_deframer

Interface
REQ-001 Parameter D_BITWIDTH, default 64, beat data width.
REQ-002 Parameter BEATS, default 8, beats per compressed block.
REQ-003 Parameter SLOTS, default 2, block buffer depth.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data_i  input  64  compressed beat from the encoder burst stream.
REQ-007 valid_i  input  1  beat on data_i/sop_i/eop_i/mode_i is valid.
REQ-008 ready_o  output  1  block accepts a beat this cycle.
REQ-009 sop_i  input  1  first beat of a block.
REQ-010 eop_i  input  1  last beat of a block.
REQ-011 mode_i  input  2  block coding mode, meaningful only on the sop beat (01 SR, 10 ZRL, 11 BPC, 00 reserved).
REQ-012 blk_data_o  output  512  assembled block; beat k occupies bits [64k+63:64k].
REQ-013 blk_mode_o  output  2  mode captured on that block's sop beat.
REQ-014 blk_valid_o  output  1  buffer head holds a complete block.
REQ-015 blk_ready_i  input  1  downstream decoder accepts the head block.
REQ-016 err_o  output  1  one-cycle framing-error pulse.
REQ-017 err_code_o  output  2  error cause, valid while err_o=1 (01 early sop, 10 orphan beat, 11 bad length).

Function
REQ-018 Beat transfer occurs iff valid_i & ready_o; block transfer occurs iff blk_valid_o & blk_ready_i.
REQ-019 ready_o SHALL be 1 iff fewer than SLOTS complete blocks are buffered, and SHALL depend on registered state only (no path from valid_i or blk_ready_i).
REQ-020 FSM states: IDLE (beat counter 0) and COLLECT (counter 1..BEATS-1).
REQ-021 IDLE + accepted beat with sop_i=1: store beat 0, capture mode_i, counter=1, go to COLLECT.
REQ-022 IDLE + accepted beat with sop_i=0: drop beat, pulse err_o with code 10, stay in IDLE.
REQ-023 COLLECT + accepted beat, sop_i=0, eop_i=0, counter<BEATS-1: store at slot counter, counter+1.
REQ-024 COLLECT + accepted beat, sop_i=0, counter=BEATS-1, eop_i=1: store beat 7, commit block to buffer tail, go to IDLE.
REQ-025 COLLECT + accepted beat, sop_i=1: discard partial block, pulse err code 01, treat this beat as beat 0 of a new block (mode captured, counter=1).
REQ-026 eop_i=1 with counter<BEATS-1, or eop_i=0 at counter=BEATS-1: discard partial block, pulse err code 11, go to IDLE.
REQ-027 A single beat with sop_i=1 and eop_i=1 in IDLE SHALL be handled as code 11 (length 1 != BEATS), go to IDLE.
REQ-028 Assembly register is separate from the buffer; the buffer is written only on a successful commit.
REQ-029 Latency: blk_valid_o rises the cycle after the eop beat is accepted when the buffer was empty.
REQ-030 Buffer is FIFO-ordered; commit and pop in the same cycle SHALL both take effect, occupancy unchanged.
REQ-031 blk_data_o/blk_mode_o SHALL be stable while blk_valid_o=1 and blk_ready_i=0.
REQ-032 Buffer full: ready_o=0; partial assembly holds its state until ready_o returns.
REQ-033 err_o SHALL not assert on an idle cycle, a rejected beat (valid_i & ~ready_o), or a successful beat.
REQ-034 Mode 00 is passed through unchanged; no error is raised.

Reset
REQ-035 rst_n=0 asynchronously forces IDLE, counter 0, buffer empty, blk_valid_o=0, err_o=0, err_code_o=00, ready_o=1 after release.
REQ-036 blk_data_o and blk_mode_o SHALL read 0 in reset.
REQ-037 Reset mid-block discards the partial block and any buffered blocks; no err_o pulse is generated.

Verification
REQ-038 8 beats 0x0..0x7 (sop on beat 0, eop on beat 7, mode 10), blk_ready_i=1 -> next cycle blk_valid_o=1, blk_mode_o=10, blk_data_o[63:0]=0x0, blk_data_o[511:448]=0x7.
REQ-039 blk_ready_i=0, 3 back-to-back valid blocks -> two blocks buffered, ready_o=0 after the 2nd eop; raise blk_ready_i -> blocks pop in order, 3rd accepted intact.
REQ-040 sop at beat 4 of a block -> err_o pulse code 01; next 8 beats form a block delivered with the new mode.
REQ-041 eop at beat 5 -> err_o code 11, nothing delivered; beat 7 without eop -> err_o code 11; a lone beat without sop in IDLE -> err_o code 10.
REQ-042 Push and pop in the same cycle with 1 block buffered -> occupancy stays 1, ready_o stays 1, order preserved.
REQ-043 rst_n low at beat 3 -> blk_valid_o=0, ready_o=1 after release; next clean block delivered correctly.
